// File: rtl/ring_counter_pkg.sv
// Shared constants and helpers for the ring/Johnson sequencer.
package ring_counter_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;
    localparam logic DIR_LEFT     = 1'b0;
    localparam logic DIR_RIGHT    = 1'b1;

    // Widest counter supported; narrower vectors are zero-extended before is_onehot.
    localparam int unsigned MAX_WIDTH = 64;

    function automatic logic is_onehot(input logic [MAX_WIDTH-1:0] vec);
        return (vec != '0) && ((vec & (vec - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/ring_step.sv
// Combinational next-state for one ring/Johnson shift, plus one-hot legality of the current state.
module ring_step
    import ring_counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic             mode,
    input  logic             dir,
    output logic [WIDTH-1:0] next_count,
    output logic             onehot_ok
);

    logic [MAX_WIDTH-1:0] count_ext;
    logic                 feed_msb;
    logic                 feed_lsb;

    always_comb begin
        count_ext = '0;
        count_ext[WIDTH-1:0] = count;
        onehot_ok = is_onehot(count_ext);

        // Johnson inverts the bit wrapping around; ring passes it straight through.
        feed_lsb = (mode == MODE_JOHNSON) ? ~count[WIDTH-1] : count[WIDTH-1];
        feed_msb = (mode == MODE_JOHNSON) ? ~count[0] : count[0];

        if (dir == DIR_LEFT) begin
            next_count = {count[WIDTH-2:0], feed_lsb};
        end else begin
            next_count = {feed_msb, count[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ring_counter_ctrl.sv
// Parametrised ring (one-hot) / Johnson counter with load, direction, wrap pulse and
// ring-mode self-correction.
module ring_counter_ctrl
    import ring_counter_pkg::*;
#(
    parameter int             WIDTH     = 8,
    parameter logic [WIDTH-1:0] RING_SEED = {1'b1, {(WIDTH-1){1'b0}}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    input  logic             dir,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH-1:0]     JOHNSON_SEED = '0;
    localparam logic [MAX_WIDTH-1:0] SEED_EXT     = MAX_WIDTH'(RING_SEED);

    if (WIDTH < 2 || WIDTH > int'(MAX_WIDTH)) begin : g_bad_width
        $error("ring_counter_ctrl: WIDTH must be in 2..MAX_WIDTH");
    end

    if (!is_onehot(SEED_EXT)) begin : g_bad_seed
        $error("ring_counter_ctrl: RING_SEED must be one-hot");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             mode_q, mode_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] step_count;
    logic             step_onehot;
    logic [WIDTH-1:0] cur_seed;

    ring_step #(
        .WIDTH (WIDTH)
    ) u_ring_step (
        .count      (count_q),
        .mode       (mode_q),
        .dir        (dir),
        .next_count (step_count),
        .onehot_ok  (step_onehot)
    );

    always_comb begin
        count_d  = count_q;
        mode_d   = mode;
        wrap_d   = 1'b0;
        err_d    = 1'b0;
        cur_seed = (mode_q == MODE_JOHNSON) ? JOHNSON_SEED : RING_SEED;

        if (load) begin
            count_d = load_val;
        end else if (mode != mode_q) begin
            count_d = (mode == MODE_JOHNSON) ? JOHNSON_SEED : RING_SEED;
        end else if (en) begin
            if (mode_q == MODE_RING && !step_onehot) begin
                count_d = RING_SEED;
                err_d   = 1'b1;
            end else begin
                count_d = step_count;
                wrap_d  = (step_count == cur_seed);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RING_SEED;
            mode_q  <= MODE_RING;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            mode_q  <= mode_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign err   = err_q;

endmodule

// File: tb/tb_ring_counter_ctrl.sv
// Directed scoreboard bench for ring_counter_ctrl at WIDTH=8.
module tb_ring_counter_ctrl;

    typedef struct {
        string      name;
        logic [7:0] count;
        logic       wrap;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic       mode = 1'b0;
    logic       dir = 1'b0;
    logic [7:0] count;
    logic       wrap;
    logic       err;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    ring_counter_ctrl #(
        .WIDTH (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .mode     (mode),
        .dir      (dir),
        .count    (count),
        .wrap     (wrap),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the state expected after the next posedge.
    task automatic vec(input string nm, input logic r, input logic e, input logic l,
                       input logic [7:0] lv, input logic m, input logic d,
                       input logic [7:0] ec, input logic ew, input logic ee);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; load = l; load_val = lv; mode = m; dir = d;
        x.name = nm; x.count = ec; x.wrap = ew; x.err = ee;
        exp_q.push_back(x);
    endtask

    // Monitor: the DUT presents a new registered state every cycle.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            checks++;
            if (count !== x.count || wrap !== x.wrap || err !== x.err) begin
                errors++;
                $display("FAIL %s: got count=%02h wrap=%b err=%b, expected count=%02h wrap=%b err=%b",
                         x.name, count, wrap, err, x.count, x.wrap, x.err);
            end
        end
    end

    logic [7:0] ring_seq [8];
    logic [7:0] john_seq [16];

    initial begin
        ring_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        john_seq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                     8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

        // Reset, including a load that must be ignored.
        vec("reset",        1, 0, 0, 8'h00, 0, 0, 8'h80, 0, 0);
        vec("reset_load",   1, 0, 1, 8'h55, 0, 0, 8'h80, 0, 0);

        // Ring left full period.
        for (int i = 0; i < 8; i++)
            vec($sformatf("ring_left_%0d", i), 0, 1, 0, 8'h00, 0, 0, ring_seq[i], i == 7, 0);

        // Switch to Johnson: reload to zero even though en=1, then 16 steps.
        vec("to_johnson",   0, 1, 0, 8'h00, 1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 16; i++)
            vec($sformatf("john_left_%0d", i), 0, 1, 0, 8'h00, 1, 0, john_seq[i], i == 15, 0);

        // Johnson right from zero.
        vec("john_right_0", 0, 1, 0, 8'h00, 1, 1, 8'h80, 0, 0);
        vec("john_right_1", 0, 1, 0, 8'h00, 1, 1, 8'hC0, 0, 0);

        // Back to ring with en=0, then illegal-state correction.
        vec("to_ring",      0, 0, 0, 8'h00, 0, 0, 8'h80, 0, 0);
        vec("load_24",      0, 0, 1, 8'h24, 0, 0, 8'h24, 0, 0);
        vec("fix_24",       0, 1, 0, 8'h00, 0, 0, 8'h80, 0, 1);
        vec("hold_after",   0, 0, 0, 8'h00, 0, 0, 8'h80, 0, 0);
        vec("load_00",      0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0);
        vec("fix_00",       0, 1, 0, 8'h00, 0, 0, 8'h80, 0, 1);

        // Direction changes and load priority over en.
        vec("load_10",      0, 0, 1, 8'h10, 0, 0, 8'h10, 0, 0);
        vec("ring_right",   0, 1, 0, 8'h00, 0, 1, 8'h08, 0, 0);
        vec("ring_left",    0, 1, 0, 8'h00, 0, 0, 8'h10, 0, 0);
        vec("load_over_en", 0, 1, 1, 8'h02, 0, 0, 8'h02, 0, 0);
        vec("load_seed",    0, 0, 1, 8'h80, 0, 0, 8'h80, 0, 0);
        vec("load_01",      0, 0, 1, 8'h01, 0, 0, 8'h01, 0, 0);
        vec("wrap_right",   0, 1, 0, 8'h00, 0, 1, 8'h80, 1, 0);

        // Reset mid-Johnson.
        vec("to_john2",     0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++)
            vec($sformatf("john2_%0d", i), 0, 1, 0, 8'h00, 1, 0, john_seq[i], 0, 0);
        vec("rst_mid",      1, 1, 0, 8'h00, 1, 0, 8'h80, 0, 0);
        vec("toggle_john",  0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
        vec("toggle_ring",  0, 0, 0, 8'h00, 0, 0, 8'h80, 0, 0);

        // Load wins over mode change; mode_q still follows, so next step is Johnson.
        vec("load_modechg", 0, 0, 1, 8'h3C, 1, 0, 8'h3C, 0, 0);
        vec("john_illegal", 0, 1, 0, 8'h00, 1, 0, 8'h79, 0, 0);
        vec("hold_john",    0, 0, 0, 8'h00, 1, 0, 8'h79, 0, 0);

        // Drain the scoreboard with a bounded wait.
        begin
            int budget;
            budget = 20;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            @(negedge clk);
            if (exp_q.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
